// File: rtl/spi_pkg.sv
// Shared SPI definitions: buffer/divider widths, TX state encoding and the
// request payload latched on Start.
package spi_pkg;

  localparam int unsigned BufAddrWidth = 10;
  localparam int unsigned DivWidth     = 8;
  localparam int unsigned DataWidth    = 8;
  localparam int unsigned BitCntWidth  = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } spi_tx_state_t;

  // Software-visible transfer request, captured as one word on Start.
  typedef struct packed {
    logic [BufAddrWidth-1:0] startAddr;
    logic [BufAddrWidth-1:0] byteCount;
    logic [DivWidth-1:0]     clkDiv;
  } spi_tx_req_t;

endpackage

// File: rtl/spi_buffer_tx_if.sv
// Bus bundle for spi_buffer_tx: register-block request, RAM read port and SPI pins.
//   master : the streamer (drives Busy/Done, RAM read request, SCK/MOSI)
//   slave  : the surrounding parent (register block, block RAM, pads)
interface spi_buffer_tx_if;
  import spi_pkg::*;

  logic                    Start;
  logic [BufAddrWidth-1:0] StartAddr;
  logic [BufAddrWidth-1:0] ByteCount;
  logic [DivWidth-1:0]     ClkDiv;
  logic                    Busy;
  logic                    Done;
  logic                    ReadEnable;
  logic [BufAddrWidth-1:0] ReadAddr;
  logic [DataWidth-1:0]    ReadData;
  logic                    SpiClk;
  logic                    SpiMosi;

  modport master (
    input  Start, StartAddr, ByteCount, ClkDiv, ReadData,
    output Busy, Done, ReadEnable, ReadAddr, SpiClk, SpiMosi
  );

  modport slave (
    output Start, StartAddr, ByteCount, ClkDiv, ReadData,
    input  Busy, Done, ReadEnable, ReadAddr, SpiClk, SpiMosi
  );

endinterface

// File: rtl/spi_half_period_counter.sv
// Loadable down-counter timing one SCK half-period.
//   Clk, nReset  : clock, async active-low reset
//   Load         : force count to LoadValue
//   Enable       : count down; on reaching zero, reload and flag terminal count
//   LoadValue    : half-period length minus 1
//   TermCount_c  : combinational, high in the last cycle of each half-period
module spi_half_period_counter
  import spi_pkg::*;
#(
  parameter int unsigned Width = DivWidth
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Load,
  input  logic             Enable,
  input  logic [Width-1:0] LoadValue,
  output logic             TermCount_c
);

  logic [Width-1:0] count;

  // Auto-reload on terminal count so consecutive half-periods need no extra load.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (Load) begin
      count <= LoadValue;
    end else if (Enable) begin
      count <= (count == '0) ? LoadValue : count - Width'(1);
    end
  end

  assign TermCount_c = Enable && (count == '0);

endmodule

// File: rtl/spi_buffer_tx.sv
// SPI mode-0 transmit streamer: reads bytes from the block-RAM read port and
// shifts them out MSB first.
//   Clk, nReset : clock (shared with RAM read port), async active-low reset
//   bus         : request (Start/StartAddr/ByteCount/ClkDiv), status (Busy/Done),
//                 RAM read port (ReadEnable/ReadAddr/ReadData), pins (SpiClk/SpiMosi)
module spi_buffer_tx
  import spi_pkg::*;
(
  input  logic             Clk,
  input  logic             nReset,
  spi_buffer_tx_if.master  bus
);

  spi_tx_state_t           state;
  spi_tx_req_t             reqIn;
  logic [BufAddrWidth-1:0] addrCnt;
  logic [BufAddrWidth-1:0] remaining;
  logic [DivWidth-1:0]     divReload;
  logic [DataWidth-1:0]    shiftReg;
  logic [BitCntWidth-1:0]  bitCnt;
  logic                    busyQ;
  logic                    doneQ;
  logic                    readEnQ;
  logic [BufAddrWidth-1:0] readAddrQ;
  logic                    spiClkQ;
  logic                    halfLoad_c;
  logic                    halfEnable_c;
  logic                    halfDone_c;

  assign reqIn = {bus.StartAddr, bus.ByteCount, bus.ClkDiv};

  // Counter is primed in LOAD and free-runs (auto-reload) through both SCK phases.
  assign halfLoad_c   = (state == LOAD);
  assign halfEnable_c = (state == SHIFT_LO) || (state == SHIFT_HI);

  spi_half_period_counter #(
    .Width (DivWidth)
  ) u_half (
    .Clk         (Clk),
    .nReset      (nReset),
    .Load        (halfLoad_c),
    .Enable      (halfEnable_c),
    .LoadValue   (divReload),
    .TermCount_c (halfDone_c)
  );

  // Transfer sequencer; every output is a register updated on state entry.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      addrCnt   <= '0;
      remaining <= '0;
      divReload <= '0;
      shiftReg  <= '0;
      bitCnt    <= '0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      readEnQ   <= 1'b0;
      readAddrQ <= '0;
      spiClkQ   <= 1'b0;
    end else begin
      readEnQ <= 1'b0;
      doneQ   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            addrCnt   <= reqIn.startAddr;
            remaining <= reqIn.byteCount;
            divReload <= reqIn.clkDiv;
            readAddrQ <= reqIn.startAddr;
            readEnQ   <= 1'b1;
            busyQ     <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          // MOSI is shiftReg[7], so loading the byte presents its MSB.
          shiftReg <= bus.ReadData;
          bitCnt   <= BitCntWidth'(7);
          addrCnt  <= addrCnt + BufAddrWidth'(1);
          state    <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (halfDone_c) begin
            spiClkQ <= 1'b1;
            state   <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (halfDone_c) begin
            spiClkQ <= 1'b0;
            if (bitCnt != '0) begin
              shiftReg <= {shiftReg[DataWidth-2:0], 1'b0};
              bitCnt   <= bitCnt - BitCntWidth'(1);
              state    <= SHIFT_LO;
            end else if (remaining != '0) begin
              remaining <= remaining - BufAddrWidth'(1);
              readAddrQ <= addrCnt;
              readEnQ   <= 1'b1;
              state     <= FETCH;
            end else begin
              shiftReg <= '0;
              busyQ    <= 1'b0;
              doneQ    <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy       = busyQ;
  assign bus.Done       = doneQ;
  assign bus.ReadEnable = readEnQ;
  assign bus.ReadAddr   = readAddrQ;
  assign bus.SpiClk     = spiClkQ;
  assign bus.SpiMosi    = shiftReg[DataWidth-1];

endmodule

// File: tb/tb_spi_buffer_tx.sv
// Self-checking bench for spi_buffer_tx: owns the block RAM model, drives
// directed transfers and compares every cycle against a timing model derived
// from the byte/bit schedule.
`timescale 1ns/1ps
module tb_spi_buffer_tx;

  logic clk;
  logic nReset;
  spi_buffer_tx_if ifc();

  spi_buffer_tx dut (
    .Clk    (clk),
    .nReset (nReset),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [1024];

  // Registered-read block RAM, one cycle latency.
  always @(posedge clk) begin
    if (ifc.ReadEnable) ifc.ReadData <= mem[ifc.ReadAddr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int startCycle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observation log
  logic [7:0] rxQ [$];
  int         reAddrQ [$];
  logic [7:0] rxCur;
  int         rxBits = 0;
  int         rxEdges = 0;
  int         reCount = 0;
  int         doneCount = 0;
  int         doneCycle = 0;
  logic       prevSck = 1'b0;

  // Model: transfer schedule as arithmetic over t = cycles since Start
  bit mActive = 0;
  int mT, mN, mH, mP, mSa;
  int k, r, s, b;
  logic [7:0] eb;

  always @(negedge clk) begin
    if (!nReset) begin
      mActive = 0;
      rxBits  = 0;
      prevSck = 1'b0;
      chk("rst_busy", 32'(ifc.Busy), 0);
      chk("rst_done", 32'(ifc.Done), 0);
      chk("rst_re",   32'(ifc.ReadEnable), 0);
      chk("rst_addr", 32'(ifc.ReadAddr), 0);
      chk("rst_sck",  32'(ifc.SpiClk), 0);
      chk("rst_mosi", 32'(ifc.SpiMosi), 0);
    end else begin
      if (mActive) begin
        if (mT <= mN * mP) begin
          k = (mT - 1) / mP;
          r = (mT - 1) % mP;
          chk("busy", 32'(ifc.Busy), 1);
          chk("done", 32'(ifc.Done), 0);
          chk("re", 32'(ifc.ReadEnable), (r == 0) ? 1 : 0);
          if (r == 0) chk("re_addr", 32'(ifc.ReadAddr), (mSa + k) % 1024);
          if (r >= 2) begin
            s  = r - 2;
            b  = s / (2 * mH);
            eb = mem[(mSa + k) % 1024];
            chk("sck", 32'(ifc.SpiClk), ((s % (2 * mH)) >= mH) ? 1 : 0);
            chk("mosi", 32'(ifc.SpiMosi), 32'(eb[7 - b]));
          end else begin
            chk("sck_gap", 32'(ifc.SpiClk), 0);
          end
        end else begin
          chk("done_pulse", 32'(ifc.Done), 1);
          chk("done_busy",  32'(ifc.Busy), 0);
          chk("done_re",    32'(ifc.ReadEnable), 0);
          chk("done_sck",   32'(ifc.SpiClk), 0);
          chk("done_mosi",  32'(ifc.SpiMosi), 0);
        end
      end else begin
        chk("idle_busy", 32'(ifc.Busy), 0);
        chk("idle_done", 32'(ifc.Done), 0);
        chk("idle_re",   32'(ifc.ReadEnable), 0);
        chk("idle_sck",  32'(ifc.SpiClk), 0);
        chk("idle_mosi", 32'(ifc.SpiMosi), 0);
      end

      // event capture
      if (!prevSck && ifc.SpiClk) begin
        rxCur = {rxCur[6:0], ifc.SpiMosi};
        rxBits++;
        rxEdges++;
        if (rxBits == 8) begin
          rxQ.push_back(rxCur);
          rxBits = 0;
        end
      end
      prevSck = ifc.SpiClk;
      if (ifc.ReadEnable) begin
        reCount++;
        reAddrQ.push_back(int'(ifc.ReadAddr));
      end
      if (ifc.Done) begin
        doneCount++;
        doneCycle = cyc;
      end

      // advance model; Start only honoured when idle (not busy, not in the Done cycle)
      if (mActive) begin
        if (mT == mN * mP + 1) mActive = 0;
        else mT++;
      end else if (ifc.Start) begin
        mActive = 1;
        mT  = 1;
        mN  = int'(ifc.ByteCount) + 1;
        mH  = int'(ifc.ClkDiv) + 1;
        mP  = 2 + 16 * mH;
        mSa = int'(ifc.StartAddr);
      end
    end
  end

  task automatic clearLog();
    rxQ.delete();
    reAddrQ.delete();
    reCount   = 0;
    doneCount = 0;
    rxEdges   = 0;
  endtask

  task automatic startXfer(input int sa, input int bc, input int div);
    @(posedge clk); #1;
    ifc.Start     = 1'b1;
    ifc.StartAddr = 10'(sa);
    ifc.ByteCount = 10'(bc);
    ifc.ClkDiv    = 8'(div);
    startCycle    = cyc;
    @(posedge clk); #1;
    ifc.Start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int d0 = doneCount;
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (doneCount > d0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bit found;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    nReset        = 1'b0;
    ifc.Start     = 1'b0;
    ifc.StartAddr = '0;
    ifc.ByteCount = '0;
    ifc.ClkDiv    = '0;
    ifc.ReadData  = '0;
    repeat (3) @(posedge clk);
    #2 nReset = 1'b1;
    repeat (2) @(posedge clk);

    // Single byte, ClkDiv=0
    clearLog();
    mem[10'h010] = 8'hA5;
    startXfer(10'h010, 0, 0);
    waitDone(100);
    chk("single_rx_count", 32'(rxQ.size()), 1);
    if (rxQ.size() >= 1) chk("single_rx_byte", 32'(rxQ[0]), 32'hA5);
    chk("single_re_count", 32'(reCount), 1);
    if (reAddrQ.size() >= 1) chk("single_re_addr", 32'(reAddrQ[0]), 32'h010);
    chk("single_duration", 32'(doneCycle - startCycle), 19);
    chk("single_done_count", 32'(doneCount), 1);

    // Multi-byte with address wrap, ClkDiv=3
    clearLog();
    mem[10'h3FE] = 8'h11;
    mem[10'h3FF] = 8'h22;
    mem[10'h000] = 8'h33;
    startXfer(10'h3FE, 2, 3);
    waitDone(400);
    chk("wrap_rx_count", 32'(rxQ.size()), 3);
    if (rxQ.size() >= 3) begin
      chk("wrap_rx0", 32'(rxQ[0]), 32'h11);
      chk("wrap_rx1", 32'(rxQ[1]), 32'h22);
      chk("wrap_rx2", 32'(rxQ[2]), 32'h33);
    end
    if (reAddrQ.size() >= 3) begin
      chk("wrap_addr0", 32'(reAddrQ[0]), 32'h3FE);
      chk("wrap_addr1", 32'(reAddrQ[1]), 32'h3FF);
      chk("wrap_addr2", 32'(reAddrQ[2]), 32'h000);
    end
    chk("wrap_duration", 32'(doneCycle - startCycle), 199);

    // Full buffer, 1024 bytes
    clearLog();
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    startXfer(0, 1023, 0);
    waitDone(20000);
    chk("full_rx_count", 32'(rxQ.size()), 1024);
    bad = 0;
    for (int i = 0; i < rxQ.size(); i++) if (rxQ[i] !== 8'(i)) bad++;
    chk("full_rx_order_bad", 32'(bad), 0);
    chk("full_re_count", 32'(reCount), 1024);
    chk("full_done_count", 32'(doneCount), 1);
    chk("full_duration", 32'(doneCycle - startCycle), 18433);

    // Start re-asserted during SHIFT_HI of byte 0 is ignored
    clearLog();
    mem[10'h020] = 8'hC3;
    mem[10'h021] = 8'h5A;
    mem[10'h100] = 8'hFF;
    startXfer(10'h020, 1, 1);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ifc.SpiClk) begin
        found = 1;
        break;
      end
    end
    chk("ign_sck_seen", 32'(found), 1);
    ifc.Start     = 1'b1;
    ifc.StartAddr = 10'h100;
    ifc.ByteCount = 10'd5;
    @(posedge clk); #1;
    ifc.Start = 1'b0;
    waitDone(200);
    repeat (40) @(posedge clk);
    chk("ign_done_count", 32'(doneCount), 1);
    chk("ign_re_count", 32'(reCount), 2);
    chk("ign_rx_count", 32'(rxQ.size()), 2);
    if (rxQ.size() >= 2) begin
      chk("ign_rx0", 32'(rxQ[0]), 32'hC3);
      chk("ign_rx1", 32'(rxQ[1]), 32'h5A);
    end
    chk("ign_duration", 32'(doneCycle - startCycle), 69);

    // Reset during byte 1, then a fresh transfer
    clearLog();
    mem[10'h030] = 8'h0F;
    mem[10'h031] = 8'hF0;
    startXfer(10'h030, 1, 1);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (rxEdges >= 12) begin
        found = 1;
        break;
      end
    end
    chk("rst_edge_seen", 32'(found), 1);
    #2 nReset = 1'b0;
    #1;
    chk("rst_now_sck",  32'(ifc.SpiClk), 0);
    chk("rst_now_mosi", 32'(ifc.SpiMosi), 0);
    chk("rst_now_busy", 32'(ifc.Busy), 0);
    chk("rst_now_done", 32'(ifc.Done), 0);
    repeat (2) @(posedge clk);
    #2 nReset = 1'b1;
    repeat (40) @(posedge clk);
    chk("rst_no_done", 32'(doneCount), 0);
    clearLog();
    startXfer(10'h030, 0, 0);
    waitDone(100);
    chk("rst_fresh_rx_count", 32'(rxQ.size()), 1);
    if (rxQ.size() >= 1) chk("rst_fresh_rx", 32'(rxQ[0]), 32'h0F);
    chk("rst_fresh_duration", 32'(doneCycle - startCycle), 19);

    // Back-to-back: Start in the cycle after Done
    repeat (3) @(posedge clk);
    clearLog();
    mem[10'h040] = 8'h81;
    mem[10'h041] = 8'h7E;
    startXfer(10'h040, 0, 0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ifc.Done) begin
        found = 1;
        break;
      end
    end
    chk("b2b_done_seen", 32'(found), 1);
    @(posedge clk); #1;
    ifc.Start     = 1'b1;
    ifc.StartAddr = 10'h041;
    ifc.ByteCount = 10'd0;
    ifc.ClkDiv    = 8'd0;
    startCycle    = cyc;
    @(posedge clk); #1;
    ifc.Start = 1'b0;
    chk("b2b_fetch_re",   32'(ifc.ReadEnable), 1);
    chk("b2b_fetch_addr", 32'(ifc.ReadAddr), 32'h041);
    chk("b2b_fetch_busy", 32'(ifc.Busy), 1);
    waitDone(100);
    chk("b2b_rx_count", 32'(rxQ.size()), 2);
    if (rxQ.size() >= 2) begin
      chk("b2b_rx0", 32'(rxQ[0]), 32'h81);
      chk("b2b_rx1", 32'(rxQ[1]), 32'h7E);
    end
    chk("b2b_duration", 32'(doneCycle - startCycle), 19);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
